wb_commit_stage: RTL and testbench
==================================

# wb_commit_stage

Parametrised successor to the single-entry writeback stage. It is a DEPTH-entry in-order commit queue between MEM and the register file and CSR unit. It accepts MEM results with a valid/ready handshake and retires at most one entry per cycle. It stalls retirement on a multi-cycle CSR read, priority-encodes the exception vector, and on exception, ertn or refetch it raises a one-cycle flush that also drops all younger queued entries.

## Interface
Parameters:
- XLEN, 32, datapath and PC width
- RAW, 5, register-file address width
- EXC_W, 16, exception-vector width; bit index maps to ECODE through the package table
- DEPTH, 2, queue entries; power of two, at least 2

Ports:
- clk  in  1  clock; one clock domain
- resetn  in  1  reset, asynchronous, active-low
- in_valid / in_ready  in / out  1 / 1  MEM handshake
- in_pc, in_result, in_vaddr  in  XLEN each  payload
- in_rf_we, in_rf_waddr  in  1, RAW  register-file write request
- in_res_from_csr, in_csr_num  in  1, 14  CSR-read instruction
- in_ertn, in_refetch  in  1 each  ertn; refetch after this instruction
- in_ebus  in  EXC_W  exception bits
- csr_re, csr_num  out  1, 14  CSR read request for the head entry
- csr_rvalid, csr_rvalue  in  1, XLEN  CSR read data, valid when csr_rvalid is high
- rf_we, rf_waddr, rf_wdata  out  1, RAW, XLEN  retire write
- ex_valid, ex_ecode, ex_esubcode, ex_pc, ex_vaddr  out  1, 6, 9, XLEN, XLEN  exception report to CSR
- ertn_flush, refetch_flush, refetch_pc  out  1, 1, XLEN
- flush_out  out  1  kill signal for IF, ID, EX and MEM
- byp_valid, byp_pending, byp_waddr, byp_wdata  out  1, 1, RAW, XLEN  forwarding from the head entry
- occupancy  out  clog2(DEPTH)+1  live entry count
- debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata  out  XLEN, 4, RAW, XLEN

## Operation
- Circular buffer with head and tail pointers that wrap modulo DEPTH, plus a count register.
- Push happens when in_valid and in_ready are both high.
- in_ready = (count < DEPTH) OR (count == DEPTH AND retire AND NOT flush). It is forced low whenever flush_out is high.
- Head entry with res_from_csr set:
  - csr_re is held high and csr_num equals the head's csr_num.
  - The entry retires only in a cycle where csr_rvalid is high.
  - byp_pending is high while the entry waits.
- All other head entries retire in the cycle they are at the head.
- On retire, the exception check uses ex = |ebus:
  - ex = 1: no register-file write. ex_valid pulses. ex_ecode comes from the lowest set bit index, since index 0 has the highest priority. ex_esubcode = ESUBCODE_ADEM only when the selected index is EBUS_ADEM, otherwise 0. flush_out pulses.
  - ex = 0 with ertn: ertn_flush and flush_out pulse.
  - ex = 0 with refetch: refetch_flush and flush_out pulse, and refetch_pc = head pc + 4.
  - Otherwise: rf_we = head rf_we, and rf_wdata = csr_rvalue if res_from_csr, else result.
- Flush: on the next edge count becomes 0 and tail is set equal to the post-retire head. A simultaneous push is refused.
- Bypass: byp_valid = head valid AND rf_we AND NOT ex. byp_wdata is meaningless while byp_pending is high.
- Debug port mirrors the rf port, with debug_wb_rf_we = {4{rf_we}}.

## Timing
- Reset values: count, head and tail are 0. Every output is 0 except in_ready, which is 1.
- Latency: an entry pushed at edge N is at the head, and may retire, in cycle N+1 at the earliest.
- Retire outputs are combinational from head storage and CSR inputs; there is no output register.
- Push and retire in the same cycle leave count unchanged. This holds when full and when going from 1 entry to empty.
- A flush pulse is exactly one cycle; no flush is generated for an empty queue.
- A resetn assertion mid-stall drops all entries asynchronously. csr_re goes low immediately.

## Structure
- Package wb_pkg holds:
  - EBUS_* bit indices.
  - The ECODE_* / ESUBCODE_* constants and an index-to-ECODE function.
  - The queue entry struct typedef.
- Sub-module exc_prio_enc: parametrised in EXC_W, a lowest-index-first priority encoder that outputs a one-hot vector and ecode.
- The queue is inline in wb_commit_stage.

## Test plan
- Back-to-back pushes of 3 ALU entries into a DEPTH=2 queue: with pc=0x1c000000, 0x1c000004 and 0x1c000008, retirements occur on consecutive cycles, in_ready never drops, and occupancy stays at 1.
- CSR-read head with csr_rvalid asserted 3 cycles late, with csr_rvalue=0xdeadbeef and waddr=4:
  - The queue stalls and fills to 2, so in_ready=0.
  - rf_wdata=0xdeadbeef retires in the csr_rvalid cycle.
  - byp_pending is high for those 3 cycles.
- Head with ebus bits ADEF and ALE both set: ex_ecode = ECODE_ADE, esubcode = 0, rf_we = 0, flush_out pulses for 1 cycle, the queued younger entry is dropped, and occupancy is 0 next cycle.
- Head with refetch and pc=0x1c000100: refetch_flush=1, refetch_pc=0x1c000104, and a concurrent in_valid is not accepted.
- resetn pulled low while the queue is full and stalled: all outputs are 0 immediately, and after release in_ready=1 and occupancy=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback commit queue: exception bit map,
// ECODE/ESUBCODE constants and the control part of a queue entry.
package wb_pkg;

    // Exception-bus bit indices; a lower index wins when several are set.
    localparam int EBUS_INT    = 0;
    localparam int EBUS_ADEF   = 1;
    localparam int EBUS_TLBR_F = 2;
    localparam int EBUS_PIF    = 3;
    localparam int EBUS_PPI_F  = 4;
    localparam int EBUS_SYS    = 5;
    localparam int EBUS_BRK    = 6;
    localparam int EBUS_INE    = 7;
    localparam int EBUS_IPE    = 8;
    localparam int EBUS_ALE    = 9;
    localparam int EBUS_ADEM   = 10;
    localparam int EBUS_TLBR_M = 11;
    localparam int EBUS_PIL    = 12;
    localparam int EBUS_PIS    = 13;
    localparam int EBUS_PME    = 14;
    localparam int EBUS_PPI_M  = 15;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0b;
    localparam logic [5:0] ECODE_BRK  = 6'h0c;
    localparam logic [5:0] ECODE_INE  = 6'h0d;
    localparam logic [5:0] ECODE_IPE  = 6'h0e;
    localparam logic [5:0] ECODE_TLBR = 6'h3f;

    localparam logic [8:0] ESUBCODE_ADEF = 9'd0;
    localparam logic [8:0] ESUBCODE_ADEM = 9'd1;

    // Map an exception-bus index to its architectural ECODE.
    function automatic logic [5:0] idx_to_ecode(input int idx);
        case (idx)
            EBUS_INT:                idx_to_ecode = ECODE_INT;
            EBUS_ADEF, EBUS_ADEM:    idx_to_ecode = ECODE_ADE;
            EBUS_TLBR_F, EBUS_TLBR_M: idx_to_ecode = ECODE_TLBR;
            EBUS_PIF:                idx_to_ecode = ECODE_PIF;
            EBUS_PPI_F, EBUS_PPI_M:  idx_to_ecode = ECODE_PPI;
            EBUS_SYS:                idx_to_ecode = ECODE_SYS;
            EBUS_BRK:                idx_to_ecode = ECODE_BRK;
            EBUS_INE:                idx_to_ecode = ECODE_INE;
            EBUS_IPE:                idx_to_ecode = ECODE_IPE;
            EBUS_ALE:                idx_to_ecode = ECODE_ALE;
            EBUS_PIL:                idx_to_ecode = ECODE_PIL;
            EBUS_PIS:                idx_to_ecode = ECODE_PIS;
            EBUS_PME:                idx_to_ecode = ECODE_PME;
            default:                 idx_to_ecode = 6'h00;
        endcase
    endfunction

    // Fixed-width control fields of a queue entry; parameter-width fields
    // (pc, result, vaddr, waddr, ebus) live in their own arrays.
    typedef struct packed {
        logic        rf_we;
        logic        res_from_csr;
        logic [13:0] csr_num;
        logic        ertn;
        logic        refetch;
    } wb_ctrl_t;

endpackage

// File: rtl/wb_commit_stage_if.sv
// MEM-to-writeback request bus: valid/ready handshake plus payload.
interface wb_commit_stage_if #(
    parameter int XLEN  = 32,
    parameter int RAW   = 5,
    parameter int EXC_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_result;
    logic [XLEN-1:0]  in_vaddr;
    logic             in_rf_we;
    logic [RAW-1:0]   in_rf_waddr;
    logic             in_res_from_csr;
    logic [13:0]      in_csr_num;
    logic             in_ertn;
    logic             in_refetch;
    logic [EXC_W-1:0] in_ebus;

    modport master (
        output in_valid, in_pc, in_result, in_vaddr, in_rf_we, in_rf_waddr,
               in_res_from_csr, in_csr_num, in_ertn, in_refetch, in_ebus,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_pc, in_result, in_vaddr, in_rf_we, in_rf_waddr,
               in_res_from_csr, in_csr_num, in_ertn, in_refetch, in_ebus,
        output in_ready
    );
endinterface

// File: rtl/exc_prio_enc.sv
// Lowest-index-first priority encoder over the exception bus.
module exc_prio_enc
    import wb_pkg::*;
#(
    parameter int EXC_W = 16
) (
    input  logic [EXC_W-1:0] i_vec,
    output logic [EXC_W-1:0] o_onehot,
    output logic [5:0]       o_ecode
);
    // Isolate the lowest set bit.
    assign o_onehot = i_vec & (~i_vec + EXC_W'(1));

    // Scan high-to-low so the lowest set index is the last one kept.
    always_comb begin
        int sel;
        sel = 0;
        for (int i = EXC_W - 1; i >= 0; i--) begin
            if (i_vec[i]) sel = i;
        end
        o_ecode = (|i_vec) ? idx_to_ecode(sel) : 6'd0;
    end
endmodule

// File: rtl/wb_commit_stage.sv
// In-order commit queue between MEM and the register file / CSR unit.
// Retires at most one entry per cycle; exceptions, ertn and refetch raise a
// one-cycle flush that also discards every younger queued entry.
module wb_commit_stage
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RAW   = 5,
    parameter int EXC_W = 16,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    wb_commit_stage_if.slave         mem,
    output logic                     csr_re,
    output logic [13:0]              csr_num,
    input  logic                     csr_rvalid,
    input  logic [XLEN-1:0]          csr_rvalue,
    output logic                     rf_we,
    output logic [RAW-1:0]           rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    output logic                     ex_valid,
    output logic [5:0]               ex_ecode,
    output logic [8:0]               ex_esubcode,
    output logic [XLEN-1:0]          ex_pc,
    output logic [XLEN-1:0]          ex_vaddr,
    output logic                     ertn_flush,
    output logic                     refetch_flush,
    output logic [XLEN-1:0]          refetch_pc,
    output logic                     flush_out,
    output logic                     byp_valid,
    output logic                     byp_pending,
    output logic [RAW-1:0]           byp_waddr,
    output logic [XLEN-1:0]          byp_wdata,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [XLEN-1:0]          debug_wb_pc,
    output logic [3:0]               debug_wb_rf_we,
    output logic [RAW-1:0]           debug_wb_rf_wnum,
    output logic [XLEN-1:0]          debug_wb_rf_wdata
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    r_head, r_tail;
    logic [CW-1:0]    r_count;
    wb_ctrl_t         r_ctrl  [DEPTH];
    logic [XLEN-1:0]  r_pc    [DEPTH];
    logic [XLEN-1:0]  r_res   [DEPTH];
    logic [XLEN-1:0]  r_vaddr [DEPTH];
    logic [RAW-1:0]   r_waddr [DEPTH];
    logic [EXC_W-1:0] r_ebus  [DEPTH];

    logic             w_head_valid, w_retire, w_ex, w_flush, w_ready, w_push;
    logic             w_write, w_is_adem;
    wb_ctrl_t         w_hc;
    logic [XLEN-1:0]  w_wdata;
    logic [EXC_W-1:0] w_onehot;
    logic [5:0]       w_ecode;
    logic [PW-1:0]    w_head_nxt;

    assign w_head_valid = (r_count != '0);
    assign w_hc         = r_ctrl[r_head];

    // A CSR-read head may only leave once the CSR unit returns its data.
    assign w_retire = w_head_valid & ~(w_hc.res_from_csr & ~csr_rvalid);
    assign w_ex     = |r_ebus[r_head];

    exc_prio_enc #(.EXC_W(EXC_W)) u_prio (
        .i_vec    (r_ebus[r_head]),
        .o_onehot (w_onehot),
        .o_ecode  (w_ecode)
    );

    generate
        if (EXC_W > EBUS_ADEM) begin : g_adem
            assign w_is_adem = w_onehot[EBUS_ADEM];
        end else begin : g_no_adem
            assign w_is_adem = 1'b0;
        end
    endgenerate

    assign ex_valid      = w_retire & w_ex;
    assign ertn_flush    = w_retire & ~w_ex & w_hc.ertn;
    assign refetch_flush = w_retire & ~w_ex & ~w_hc.ertn & w_hc.refetch;
    assign w_flush       = ex_valid | ertn_flush | refetch_flush;
    assign flush_out     = w_flush;

    assign ex_ecode    = ex_valid ? w_ecode : 6'd0;
    assign ex_esubcode = (ex_valid & w_is_adem) ? ESUBCODE_ADEM : 9'd0;
    assign ex_pc       = ex_valid ? r_pc[r_head] : '0;
    assign ex_vaddr    = ex_valid ? r_vaddr[r_head] : '0;
    assign refetch_pc  = refetch_flush ? (r_pc[r_head] + XLEN'(4)) : '0;

    // Register-file write only for a plain retire (no exception/ertn/refetch).
    assign w_write  = w_retire & ~w_ex & ~w_hc.ertn & ~w_hc.refetch;
    assign w_wdata  = w_hc.res_from_csr ? csr_rvalue : r_res[r_head];
    assign rf_we    = w_write & w_hc.rf_we;
    assign rf_waddr = w_retire ? r_waddr[r_head] : '0;
    assign rf_wdata = w_retire ? w_wdata : '0;

    assign csr_re  = w_head_valid & w_hc.res_from_csr;
    assign csr_num = csr_re ? w_hc.csr_num : 14'd0;

    assign byp_valid   = w_head_valid & w_hc.rf_we & ~w_ex;
    assign byp_pending = csr_re & ~csr_rvalid;
    assign byp_waddr   = byp_valid ? r_waddr[r_head] : '0;
    assign byp_wdata   = byp_valid ? w_wdata : '0;

    assign debug_wb_pc       = w_retire ? r_pc[r_head] : '0;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

    assign occupancy = r_count;

    // Full queue still accepts when the head leaves, but never during a flush.
    assign w_ready = ~w_flush & ((r_count < CW'(DEPTH)) |
                                 ((r_count == CW'(DEPTH)) & w_retire));
    assign mem.in_ready = w_ready;
    assign w_push       = mem.in_valid & w_ready;
    assign w_head_nxt   = r_head + PW'(w_retire);

    // Pointer/count update; a flush empties the queue behind the retiring head.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_head  <= w_head_nxt;
            r_tail  <= w_head_nxt;
            r_count <= '0;
        end else begin
            r_head  <= w_head_nxt;
            r_tail  <= r_tail + PW'(w_push);
            r_count <= r_count + CW'(w_push) - CW'(w_retire);
        end
    end

    // Entry storage; contents are only observed while the count covers them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ctrl[r_tail]  <= '{rf_we:        mem.in_rf_we,
                                 res_from_csr: mem.in_res_from_csr,
                                 csr_num:      mem.in_csr_num,
                                 ertn:         mem.in_ertn,
                                 refetch:      mem.in_refetch};
            r_pc[r_tail]    <= mem.in_pc;
            r_res[r_tail]   <= mem.in_result;
            r_vaddr[r_tail] <= mem.in_vaddr;
            r_waddr[r_tail] <= mem.in_rf_waddr;
            r_ebus[r_tail]  <= mem.in_ebus;
        end
    end
endmodule

// File: tb/tb_wb_commit_stage.sv
// Directed bench for wb_commit_stage (DEPTH=2).
module tb_wb_commit_stage;
    localparam int XLEN = 32, RAW = 5, EXC_W = 16, DEPTH = 2;

    logic clk, resetn;
    logic csr_rvalid;
    logic [XLEN-1:0] csr_rvalue;
    logic csr_re, rf_we, ex_valid, ertn_flush, refetch_flush, flush_out;
    logic byp_valid, byp_pending;
    logic [13:0] csr_num;
    logic [RAW-1:0] rf_waddr, byp_waddr, debug_wb_rf_wnum;
    logic [XLEN-1:0] rf_wdata, ex_pc, ex_vaddr, refetch_pc, byp_wdata;
    logic [XLEN-1:0] debug_wb_pc, debug_wb_rf_wdata;
    logic [5:0] ex_ecode;
    logic [8:0] ex_esubcode;
    logic [1:0] occupancy;
    logic [3:0] debug_wb_rf_we;

    int checks = 0;
    int errors = 0;

    wb_commit_stage_if #(.XLEN(XLEN), .RAW(RAW), .EXC_W(EXC_W)) mif ();

    wb_commit_stage #(.XLEN(XLEN), .RAW(RAW), .EXC_W(EXC_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .mem(mif),
        .csr_re(csr_re), .csr_num(csr_num), .csr_rvalid(csr_rvalid), .csr_rvalue(csr_rvalue),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .ex_valid(ex_valid), .ex_ecode(ex_ecode), .ex_esubcode(ex_esubcode),
        .ex_pc(ex_pc), .ex_vaddr(ex_vaddr),
        .ertn_flush(ertn_flush), .refetch_flush(refetch_flush), .refetch_pc(refetch_pc),
        .flush_out(flush_out),
        .byp_valid(byp_valid), .byp_pending(byp_pending), .byp_waddr(byp_waddr), .byp_wdata(byp_wdata),
        .occupancy(occupancy),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mif.in_valid = 1'b0;
        mif.in_pc = '0; mif.in_result = '0; mif.in_vaddr = '0;
        mif.in_rf_we = 1'b0; mif.in_rf_waddr = '0;
        mif.in_res_from_csr = 1'b0; mif.in_csr_num = '0;
        mif.in_ertn = 1'b0; mif.in_refetch = 1'b0; mif.in_ebus = '0;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] res, input logic we,
                        input logic [4:0] wa, input logic csr, input logic refetch,
                        input logic [15:0] ebus, input logic [31:0] vaddr);
        mif.in_valid = 1'b1;
        mif.in_pc = pc; mif.in_result = res; mif.in_vaddr = vaddr;
        mif.in_rf_we = we; mif.in_rf_waddr = wa;
        mif.in_res_from_csr = csr; mif.in_csr_num = csr ? 14'h00c : 14'h0;
        mif.in_ertn = 1'b0; mif.in_refetch = refetch; mif.in_ebus = ebus;
    endtask

    initial begin
        resetn = 1'b0; csr_rvalid = 1'b0; csr_rvalue = '0;
        idle();
        #2;
        // reset state
        chk("rst_in_ready", mif.in_ready, 1);
        chk("rst_occ", occupancy, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_csr_re", csr_re, 0);
        chk("rst_flush", flush_out, 0);
        #10 resetn = 1'b1;
        tick();

        // three back-to-back ALU entries
        push(32'h1c000000, 32'h11, 1, 5'd1, 0, 0, 16'h0, 0); #1;
        chk("b2b0_ready", mif.in_ready, 1);
        tick();
        push(32'h1c000004, 32'h12, 1, 5'd2, 0, 0, 16'h0, 0); #1;
        chk("b2b1_pc", debug_wb_pc, 32'h1c000000);
        chk("b2b1_we", rf_we, 1);
        chk("b2b1_wdata", rf_wdata, 32'h11);
        chk("b2b1_dbgwe", debug_wb_rf_we, 4'hf);
        chk("b2b1_ready", mif.in_ready, 1);
        chk("b2b1_occ", occupancy, 1);
        tick();
        push(32'h1c000008, 32'h13, 1, 5'd3, 0, 0, 16'h0, 0); #1;
        chk("b2b2_pc", debug_wb_pc, 32'h1c000004);
        chk("b2b2_ready", mif.in_ready, 1);
        chk("b2b2_occ", occupancy, 1);
        tick();
        idle(); #1;
        chk("b2b3_pc", debug_wb_pc, 32'h1c000008);
        chk("b2b3_waddr", rf_waddr, 3);
        chk("b2b3_occ", occupancy, 1);
        tick();
        chk("b2b_empty", occupancy, 0);

        // CSR-read head, csr_rvalid three cycles late
        push(32'h1c000010, 32'h0, 1, 5'd4, 1, 0, 16'h0, 0); #1;
        tick();
        push(32'h1c000014, 32'h22, 1, 5'd5, 0, 0, 16'h0, 0); #1;
        chk("csr_re", csr_re, 1);
        chk("csr_num", csr_num, 14'h00c);
        chk("csr_pend1", byp_pending, 1);
        chk("csr_bypwa", byp_waddr, 4);
        chk("csr_noret", rf_we, 0);
        chk("csr_ready1", mif.in_ready, 1);
        tick();
        idle(); #1;
        chk("csr_occ2", occupancy, 2);
        chk("csr_full", mif.in_ready, 0);
        chk("csr_pend2", byp_pending, 1);
        tick();
        chk("csr_pend3", byp_pending, 1);
        chk("csr_full3", mif.in_ready, 0);
        tick();
        csr_rvalid = 1'b1; csr_rvalue = 32'hdeadbeef; #1;
        chk("csr_ret_we", rf_we, 1);
        chk("csr_ret_wa", rf_waddr, 4);
        chk("csr_ret_wd", rf_wdata, 32'hdeadbeef);
        chk("csr_ret_pend", byp_pending, 0);
        chk("csr_ret_ready", mif.in_ready, 1);
        tick();
        csr_rvalid = 1'b0; csr_rvalue = '0; #1;
        chk("csr_next_wd", rf_wdata, 32'h22);
        chk("csr_next_occ", occupancy, 1);
        tick();
        chk("csr_empty", occupancy, 0);

        // exception head with ADEF+ALE, younger entry queued behind it
        push(32'h1c000020, 32'h0, 0, 5'd0, 1, 0, 16'h0, 0); #1;
        tick();
        push(32'h1c000024, 32'h33, 1, 5'd6, 0, 0, 16'h0202, 32'h1234); #1;
        tick();
        push(32'h1c000028, 32'h44, 1, 5'd7, 0, 0, 16'h0, 0);
        csr_rvalid = 1'b1; csr_rvalue = 32'h5; #1;
        chk("exc_fill_ready", mif.in_ready, 1);
        tick();
        idle(); csr_rvalid = 1'b0; #1;
        chk("exc_valid", ex_valid, 1);
        chk("exc_ecode", ex_ecode, 6'h08);
        chk("exc_esub", ex_esubcode, 0);
        chk("exc_pc", ex_pc, 32'h1c000024);
        chk("exc_vaddr", ex_vaddr, 32'h1234);
        chk("exc_rf_we", rf_we, 0);
        chk("exc_flush", flush_out, 1);
        chk("exc_occ", occupancy, 2);
        chk("exc_ready", mif.in_ready, 0);
        tick();
        chk("exc_drop_occ", occupancy, 0);
        chk("exc_flush_off", flush_out, 0);
        chk("exc_drop_we", rf_we, 0);

        // ADEM alone selects the ADEM subcode
        push(32'h1c000030, 32'h0, 1, 5'd8, 0, 0, 16'h0400, 32'h55); #1;
        tick();
        idle(); #1;
        chk("adem_ecode", ex_ecode, 6'h08);
        chk("adem_esub", ex_esubcode, 1);
        tick();

        // refetch head; concurrent push is refused
        push(32'h1c000100, 32'h0, 0, 5'd0, 0, 1, 16'h0, 0); #1;
        tick();
        push(32'h1c000104, 32'h66, 1, 5'd9, 0, 0, 16'h0, 0); #1;
        chk("rf_flush", refetch_flush, 1);
        chk("rf_pc", refetch_pc, 32'h1c000104);
        chk("rf_ready", mif.in_ready, 0);
        chk("rf_flushout", flush_out, 1);
        tick();
        idle(); #1;
        chk("rf_occ", occupancy, 0);
        chk("rf_flush_off", flush_out, 0);

        // reset while full and stalled
        push(32'h1c000200, 32'h0, 1, 5'd10, 1, 0, 16'h0, 0); #1;
        tick();
        push(32'h1c000204, 32'h77, 1, 5'd11, 0, 0, 16'h0, 0); #1;
        tick();
        idle(); #1;
        chk("stall_occ", occupancy, 2);
        chk("stall_csr_re", csr_re, 1);
        #2 resetn = 1'b0; #1;
        chk("arst_csr_re", csr_re, 0);
        chk("arst_occ", occupancy, 0);
        chk("arst_pend", byp_pending, 0);
        chk("arst_byp", byp_valid, 0);
        chk("arst_csr_num", csr_num, 0);
        chk("arst_ready", mif.in_ready, 1);
        #2 resetn = 1'b1;
        tick();
        chk("post_ready", mif.in_ready, 1);
        chk("post_occ", occupancy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
